core_exu_div_ctrl: RTL and testbench
====================================

# core_exu_div_ctrl

Issue and writeback controller for the iterative divider in the execute unit. Accepts RV32M DIV/DIVU/REM/REMU requests from the EXU, converts operands to magnitudes plus sign flags, and starts the divider. Stalls the pipeline while the divider runs, then delivers the signed result to the register-file write port. Handles pipeline flush while a divide is in flight.

## Interface
- No parameters; widths come from `chip_param.v` (`DATA_BUS_WIDTH`=32, `REG_BUS_WIDTH`=5).
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- req_vld_i  in  1  divide request valid from EXU.
- funct3_i  in  3  3'd4 DIV, 3'd5 DIVU, 3'd6 REM, 3'd7 REMU; other values never presented with req_vld_i.
- rs1_data_i / rs2_data_i  in  32  dividend / divisor.
- rd_addr_i  in  5  destination register.
- flush_i  in  1  pipeline flush; kills any in-flight request.
- div_data1_o / div_data2_o  out  32  dividend / divisor magnitude to divider.
- div_op_o  out  1  1 = quotient, 0 = remainder.
- div_q_sign_o / div_r_sign_o  out  1  negate-quotient / negate-remainder flags.
- div_reg_waddr_o  out  5  rd forwarded to divider.
- div_start_o  out  1  one-cycle start pulse.
- div_data_i  in  32  divider result.
- div_data_vld_i  in  1  divider result valid, one cycle.
- div_hold_i  in  1  divider busy; informational only, not used for sequencing.
- stall_o  out  1  holds EXU/upstream.
- wb_en_o / wb_addr_o / wb_data_o  out  1/5/32  register-file write.
- busy_o  out  1  state != IDLE.

## Operation
- States: IDLE, START, WAIT, DONE, DRAIN.
- Operand conversion, registered on accept:
  - Signed ops (DIV, REM): magnitude = two's-complement absolute value. 0x8000_0000 stays 0x8000_0000 unsigned.
  - Unsigned ops: operands pass through.
- Sign flags:
  - q_sign = signed & (rs1[31] ^ rs2[31]) & (rs2 != 0).
  - r_sign = signed & rs1[31].
  - With these flags, divide-by-zero gives quotient 0xFFFF_FFFF and remainder rs1.
  - Overflow (0x8000_0000 / -1) gives quotient 0x8000_0000 and remainder 0 with no special case.
- State transitions:
  - IDLE → START: req_vld_i & ~flush_i. Latch converted operands, op, rd.
  - START: div_start_o = 1. Go to WAIT, or DRAIN if flush_i. If div_data_vld_i is already asserted, that result belongs to no one and is ignored.
  - WAIT → DONE: div_data_vld_i. Capture div_data_i into the wb register. If flush_i and div_data_vld_i occur together, flush wins: go to IDLE with no writeback.
  - WAIT → DRAIN: flush_i without div_data_vld_i.
  - DONE: wb_en_o = 1 for one cycle, then IDLE. flush_i in DONE does not suppress the writeback (the instruction has completed).
  - DRAIN: wait for div_data_vld_i, discard the result, go to IDLE. wb_en_o stays 0.
- A new request is only accepted in IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, internal registers 0.
- Reset mid-operation returns to IDLE immediately. The divider shares rst_n_i.
- Accept in cycle T.
  - div_start_o is high in T+1.
  - The divider asserts div_data_vld_i in T+2 for zero divisor or divisor > dividend, otherwise in T+34.
  - wb_en_o is high in the cycle after div_data_vld_i: T+3 (short) or T+35 (normal).
- stall_o (combinational):
  - High in IDLE when req_vld_i & ~flush_i.
  - High in START and WAIT.
  - High in DRAIN when req_vld_i.
  - Low in DONE, so the stalled instruction retires in the writeback cycle.
- wb_addr_o and wb_data_o are valid only while wb_en_o = 1, and are 0 otherwise.

## Configuration
- CORE_DIV_CACHE_EN defined:
  - A one-entry result cache holds {valid, funct3, rs1, rs2, result}.
  - On an IDLE accept whose funct3, rs1 and rs2 all match a valid entry, the controller goes directly to DONE in T+1 with the cached result and issues no div_start_o. stall_o is high in T only.
  - The entry is written on every divider-sourced DONE. Results discarded in DRAIN are never cached.
  - valid is cleared by reset.
- Undefined: no cache. Every request goes through START.

## Test plan
- DIVU 100/7, rd=5 → div_start_o at T+1; wb_en_o at T+35 with addr 5, data 14. REMU with the same operands → data 2.
- DIV -7/2 → div_q_sign_o=1, div_data1_o=7; wb data 0xFFFF_FFFD. REM -7/2 → 0xFFFF_FFFF.
- DIV x/0 with x=0x1234 → wb at T+3 with data 0xFFFF_FFFF. REM x/0 → 0x1234.
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000. REM with the same operands → 0.
- flush_i in T+10 of a DIVU 100/7 → DRAIN, no wb_en_o. A new request held during drain is accepted in the cycle after div_data_vld_i.
- With CORE_DIV_CACHE_EN: repeat DIVU 100/7 back-to-back → second request has no div_start_o and wb_en_o at T+1 with data 14. Reset between the two requests → second request runs the full 35 cycles.

Source files
------------

// File: rtl/core_exu_div_ctrl.sv
// Issue/writeback controller for the iterative RV32M divider: operand sign handling, start
// pulse, pipeline stall, flush draining. Define CORE_DIV_CACHE_EN for a one-entry result cache.

`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif
`ifndef REG_BUS_WIDTH
`define REG_BUS_WIDTH 5
`endif

module core_exu_div_ctrl (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        req_vld_i,
  input  logic [2:0]                  funct3_i,
  input  logic [`DATA_BUS_WIDTH-1:0]  rs1_data_i,
  input  logic [`DATA_BUS_WIDTH-1:0]  rs2_data_i,
  input  logic [`REG_BUS_WIDTH-1:0]   rd_addr_i,
  input  logic                        flush_i,
  output logic [`DATA_BUS_WIDTH-1:0]  div_data1_o,
  output logic [`DATA_BUS_WIDTH-1:0]  div_data2_o,
  output logic                        div_op_o,
  output logic                        div_q_sign_o,
  output logic                        div_r_sign_o,
  output logic [`REG_BUS_WIDTH-1:0]   div_reg_waddr_o,
  output logic                        div_start_o,
  input  logic [`DATA_BUS_WIDTH-1:0]  div_data_i,
  input  logic                        div_data_vld_i,
  input  logic                        div_hold_i,
  output logic                        stall_o,
  output logic                        wb_en_o,
  output logic [`REG_BUS_WIDTH-1:0]   wb_addr_o,
  output logic [`DATA_BUS_WIDTH-1:0]  wb_data_o,
  output logic                        busy_o
);

  localparam int unsigned DataW = `DATA_BUS_WIDTH;
  localparam int unsigned RegW  = `REG_BUS_WIDTH;

  typedef enum logic [2:0] {StIdle, StStart, StWait, StDone, StDrain} state_e;

  state_e            state_q;
  logic [DataW-1:0]  data1_q, data2_q;
  logic              op_q, q_sign_q, r_sign_q, start_q;
  logic [RegW-1:0]   waddr_q;
  logic              wb_en_q;
  logic [RegW-1:0]   wb_addr_q;
  logic [DataW-1:0]  wb_data_q;

  logic              is_signed, rs1_neg, rs2_neg;
  logic [DataW-1:0]  rs1_mag, rs2_mag;
  logic              q_sign, r_sign, accept;
  logic              cache_hit;
  logic [DataW-1:0]  cache_res;

  // funct3[2] is always set for divides; the divider's busy flag is not used for sequencing.
  logic unused_in;
  assign unused_in = ^{div_hold_i, funct3_i[2]};

  // funct3[0] clear selects the signed forms (DIV/REM), funct3[1] set selects remainder.
  always_comb begin
    is_signed = ~funct3_i[0];
    rs1_neg   = is_signed & rs1_data_i[DataW-1];
    rs2_neg   = is_signed & rs2_data_i[DataW-1];
    rs1_mag   = rs1_neg ? (~rs1_data_i + DataW'(1)) : rs1_data_i;
    rs2_mag   = rs2_neg ? (~rs2_data_i + DataW'(1)) : rs2_data_i;
    q_sign    = is_signed & (rs1_data_i[DataW-1] ^ rs2_data_i[DataW-1]) & (|rs2_data_i);
    r_sign    = rs1_neg;
    accept    = (state_q == StIdle) & req_vld_i & ~flush_i;
  end

`ifdef CORE_DIV_CACHE_EN
  logic              cache_vld_q;
  logic [2:0]        cache_f3_q, pend_f3_q;
  logic [DataW-1:0]  cache_rs1_q, cache_rs2_q, cache_res_q;
  logic [DataW-1:0]  pend_rs1_q, pend_rs2_q;
  logic              cache_fill;

  assign cache_hit  = cache_vld_q & (cache_f3_q == funct3_i) &
                      (cache_rs1_q == rs1_data_i) & (cache_rs2_q == rs2_data_i);
  assign cache_res  = cache_res_q;
  // Only results that actually reach writeback from the divider are remembered.
  assign cache_fill = (state_q == StWait) & div_data_vld_i & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cache_vld_q <= 1'b0;
      cache_f3_q  <= '0;
      cache_rs1_q <= '0;
      cache_rs2_q <= '0;
      cache_res_q <= '0;
      pend_f3_q   <= '0;
      pend_rs1_q  <= '0;
      pend_rs2_q  <= '0;
    end else begin
      if (accept && !cache_hit) begin
        pend_f3_q  <= funct3_i;
        pend_rs1_q <= rs1_data_i;
        pend_rs2_q <= rs2_data_i;
      end
      if (cache_fill) begin
        cache_vld_q <= 1'b1;
        cache_f3_q  <= pend_f3_q;
        cache_rs1_q <= pend_rs1_q;
        cache_rs2_q <= pend_rs2_q;
        cache_res_q <= div_data_i;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      data1_q   <= '0;
      data2_q   <= '0;
      op_q      <= 1'b0;
      q_sign_q  <= 1'b0;
      r_sign_q  <= 1'b0;
      waddr_q   <= '0;
      start_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      start_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (cache_hit) begin
              state_q   <= StDone;
              wb_en_q   <= 1'b1;
              wb_addr_q <= rd_addr_i;
              wb_data_q <= cache_res;
            end else begin
              state_q  <= StStart;
              start_q  <= 1'b1;
              data1_q  <= rs1_mag;
              data2_q  <= rs2_mag;
              op_q     <= ~funct3_i[1];
              q_sign_q <= q_sign;
              r_sign_q <= r_sign;
              waddr_q  <= rd_addr_i;
            end
          end
        end
        // A result valid during START predates this request and is ignored.
        StStart: state_q <= flush_i ? StDrain : StWait;
        StWait: begin
          if (div_data_vld_i) begin
            if (flush_i) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StDone;
              wb_en_q   <= 1'b1;
              wb_addr_q <= waddr_q;
              wb_data_q <= div_data_i;
            end
          end else if (flush_i) begin
            state_q <= StDrain;
          end
        end
        StDone:  state_q <= StIdle;
        StDrain: if (div_data_vld_i) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Low in DONE so the stalled instruction retires in its writeback cycle.
  always_comb begin
    stall_o = 1'b0;
    unique case (state_q)
      StIdle:          stall_o = req_vld_i & ~flush_i;
      StStart, StWait: stall_o = 1'b1;
      StDrain:         stall_o = req_vld_i;
      default:         stall_o = 1'b0;
    endcase
  end

  assign div_data1_o     = data1_q;
  assign div_data2_o     = data2_q;
  assign div_op_o        = op_q;
  assign div_q_sign_o    = q_sign_q;
  assign div_r_sign_o    = r_sign_q;
  assign div_reg_waddr_o = waddr_q;
  assign div_start_o     = start_q;
  assign wb_en_o         = wb_en_q;
  assign wb_addr_o       = wb_addr_q;
  assign wb_data_o       = wb_data_q;
  assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_core_exu_div_ctrl.sv
// Scoreboard bench for core_exu_div_ctrl: behavioural divider, RV32M reference results,
// start/writeback timing queues checked by an independent monitor.

module tb_core_exu_div_ctrl;

  logic        clk, rst_n;
  logic        req_vld, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_addr;
  logic [31:0] div_data1_o, div_data2_o;
  logic        div_op_o, div_q_sign_o, div_r_sign_o, div_start_o;
  logic [4:0]  div_reg_waddr_o;
  logic [31:0] div_data;
  logic        div_vld, div_hold;
  logic        stall_o, wb_en_o, busy_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;

  core_exu_div_ctrl dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .req_vld_i       (req_vld),
    .funct3_i        (funct3),
    .rs1_data_i      (rs1),
    .rs2_data_i      (rs2),
    .rd_addr_i       (rd_addr),
    .flush_i         (flush),
    .div_data1_o     (div_data1_o),
    .div_data2_o     (div_data2_o),
    .div_op_o        (div_op_o),
    .div_q_sign_o    (div_q_sign_o),
    .div_r_sign_o    (div_r_sign_o),
    .div_reg_waddr_o (div_reg_waddr_o),
    .div_start_o     (div_start_o),
    .div_data_i      (div_data),
    .div_data_vld_i  (div_vld),
    .div_hold_i      (div_hold),
    .stall_o         (stall_o),
    .wb_en_o         (wb_en_o),
    .wb_addr_o       (wb_addr_o),
    .wb_data_o       (wb_data_o),
    .busy_o          (busy_o)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } wb_t;

  wb_t  wq[$];
  int   sq[$];
  int   cyc;
  int   n_vec, n_err;
  bit          c_vld;
  logic [2:0]  c_f3;
  logic [31:0] c_a, c_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mag(input bit s, input logic [31:0] v);
    return (s && v[31]) ? (32'd0 - v) : v;
  endfunction

  // RV32M architectural results.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    bit ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m1, m2;
    m1 = mag(!f3[0], a);
    m2 = mag(!f3[0], b);
    return (m2 == 0 || m2 > m1) ? 2 : 34;
  endfunction

  function automatic bit cache_hit(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef CORE_DIV_CACHE_EN
    return c_vld && (c_f3 == f3) && (c_a == a) && (c_b == b);
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural iterative divider: works on magnitudes, negates per the sign flags.
  initial begin
    bit          pend;
    int          cnt;
    logic [31:0] q, r, res;
    pend = 0; cnt = 0; res = 0;
    div_vld = 1'b0; div_data = '0; div_hold = 1'b0;
    forever begin
      @(negedge clk);
      div_vld = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            div_vld  = 1'b1;
            div_data = res;
            pend     = 0;
          end
        end
        if (div_start_o) begin
          q = (div_data2_o == 0) ? 32'hFFFF_FFFF : div_data1_o / div_data2_o;
          r = (div_data2_o == 0) ? div_data1_o : div_data1_o % div_data2_o;
          if (div_q_sign_o) q = 32'd0 - q;
          if (div_r_sign_o) r = 32'd0 - r;
          res  = div_op_o ? q : r;
          cnt  = (div_data2_o == 0 || div_data2_o > div_data1_o) ? 1 : 33;
          pend = 1;
        end
      end
      div_hold = pend;
    end
  end

  // Monitor: pops expectations whenever the DUT starts the divider or writes back.
  initial begin
    wb_t e;
    int  es;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (div_start_o) begin
          if (sq.size() == 0) begin
            chk("unexpected_start", 1, 0);
          end else begin
            es = sq.pop_front();
            chk("start_cycle", cyc, es);
          end
        end
        if (wb_en_o) begin
          chk("wb_stall_low", stall_o, 0);
          if (wq.size() == 0) begin
            chk("unexpected_wb", 1, 0);
          end else begin
            e = wq.pop_front();
            chk("wb_addr", wb_addr_o, e.rd);
            chk("wb_data", wb_data_o, e.data);
            chk("wb_cycle", cyc, e.cyc);
          end
        end else begin
          chk("wb_idle_zero", {wb_addr_o, wb_data_o}, 0);
        end
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0; req_vld = 1'b0; flush = 1'b0;
    #1;
    chk("reset_operands", {div_data1_o, div_data2_o}, 0);
    chk("reset_ctrl", {div_op_o, div_q_sign_o, div_r_sign_o, div_reg_waddr_o, div_start_o,
                       stall_o, wb_en_o, wb_addr_o, busy_o}, 0);
    chk("reset_wb_data", wb_data_o, 0);
    wq.delete();
    sq.delete();
    c_vld = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present a request; it is accepted dly cycles later and held until it retires.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int dly);
    wb_t         e;
    int          t0, n, lat;
    bit          hit, sgn;
    logic [31:0] res;
    sgn = !f3[0];
    lat = lat_of(f3, a, b);
    res = ref_div(f3, a, b);
    hit = cache_hit(f3, a, b);
    t0  = cyc + dly;
    req_vld = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_addr = rd;
    e.rd = rd; e.data = res;
    if (hit) begin
      e.cyc = t0 + 1;
    end else begin
      sq.push_back(t0 + 1);
      e.cyc = t0 + lat + 1;
    end
    wq.push_back(e);
    #1;
    chk("stall_on_req", stall_o, 1);
    if (!hit) begin
      repeat (dly + 1) @(negedge clk);
      chk("div_operands", {div_data1_o, div_data2_o}, {mag(sgn, a), mag(sgn, b)});
      chk("div_ctrl", {div_op_o, div_q_sign_o, div_r_sign_o, div_reg_waddr_o},
          {!f3[1], sgn && (a[31] ^ b[31]) && (b != 0), sgn && a[31], rd});
    end
    n = 0;
    while (stall_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_release", n < 200, 1);
    if (!hit) begin
      c_vld = 1; c_f3 = f3; c_a = a; c_b = b;
    end
    @(negedge clk);
    req_vld = 1'b0;
  endtask

  // Flush k cycles after accept (1 <= k <= divider latency); no writeback may follow.
  task automatic flush_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int unsigned kr);
    int t0, lat, k, n;
    if (cache_hit(f3, a, b)) begin
      issue(f3, a, b, rd, 0);
      return;
    end
    lat = lat_of(f3, a, b);
    k   = 1 + int'(kr % lat);
    t0  = cyc;
    req_vld = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_addr = rd;
    sq.push_back(t0 + 1);
    repeat (k) @(negedge clk);
    flush = 1'b1; req_vld = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("flush_idle_cycle", cyc, t0 + lat + 1);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int          t0;
    n_vec = 0; n_err = 0; c_vld = 0;
    rst_n = 1'b1; req_vld = 1'b0; flush = 1'b0;
    funct3 = 3'd4; rs1 = '0; rs2 = '0; rd_addr = '0;
    @(negedge clk);
    apply_reset();

    issue(3'd5, 32'd100, 32'd7, 5'd5, 0);
    issue(3'd7, 32'd100, 32'd7, 5'd5, 0);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 0);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    issue(3'd4, 32'h0000_1234, 32'd0, 5'd6, 0);
    issue(3'd6, 32'h0000_1234, 32'd0, 5'd7, 0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);

    // Request and flush together in IDLE: neither stalled nor accepted.
    req_vld = 1'b1; flush = 1'b1; funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd2;
    #1;
    chk("idle_flush_stall", stall_o, 0);
    @(negedge clk);
    chk("idle_flush_busy", busy_o, 0);
    req_vld = 1'b0; flush = 1'b0;

    // Flush mid-divide, then a request held through DRAIN.
    apply_reset();
    t0 = cyc;
    req_vld = 1'b1; funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd_addr = 5'd5;
    sq.push_back(t0 + 1);
    repeat (10) @(negedge clk);
    flush = 1'b1; req_vld = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("drain_busy_stall", {busy_o, stall_o}, 2'b10);
    repeat (9) @(negedge clk);
    issue(3'd7, 32'd100, 32'd7, 5'd9, (t0 + 35) - cyc);

    flush_req(3'd5, 32'd1000, 32'd3, 5'd10, 0);
    flush_req(3'd5, 32'd1000, 32'd3, 5'd10, 33);
    flush_req(3'd4, 32'd5, 32'd0, 5'd11, 1);

    // Reset in the middle of a divide.
    t0 = cyc;
    req_vld = 1'b1; funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd_addr = 5'd5;
    sq.push_back(t0 + 1);
    repeat (5) @(negedge clk);
    apply_reset();
    @(negedge clk);
    chk("post_reset_idle", busy_o, 0);

    // Repeated identical request, then again after reset.
    issue(3'd5, 32'd100, 32'd7, 5'd5, 0);
    issue(3'd5, 32'd100, 32'd7, 5'd5, 0);
    apply_reset();
    issue(3'd5, 32'd100, 32'd7, 5'd5, 0);

    f3 = 3'd4; a = 32'd1; b = 32'd1;
    for (int i = 0; i < 40; i++) begin
      if (i == 0 || $urandom_range(0, 4) != 0) begin
        f3 = 3'(4 + $urandom_range(0, 3));
        case ($urandom_range(0, 5))
          0: begin a = $urandom; b = $urandom; end
          1: begin a = $urandom; b = $urandom_range(1, 15); end
          2: begin a = $urandom; b = 32'd0; end
          3: begin a = $urandom_range(0, 100); b = $urandom_range(101, 5000); end
          4: begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom; end
          default: begin
            a = 32'd0 - $urandom_range(0, 1000);
            b = $urandom_range(0, 1) ? 32'd0 - $urandom_range(1, 20) : $urandom_range(1, 20);
          end
        endcase
      end
      rd = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 5) == 0) flush_req(f3, a, b, rd, $urandom);
      else issue(f3, a, b, rd, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", wq.size() + sq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
